input_current_scheduler: RTL and testbench
==========================================

Name: input_current_scheduler

Overview:
- Sequencer for the per-neuron input-current datapath.
- Replaces the M-wide parallel weight sum with one signed 8-bit multiply-free accumulate step per cycle, walking synapse index 0..M-1.
- Accumulates the weights of synapses whose spike bit is set, clips the sum to a signed 8-bit input current, and reports completion with a start/busy/done handshake.
- Sits between the spike/weight configuration registers and the neuron membrane-update logic.

Parameters:
- M, 24, number of synapses (input spikes and 8-bit weights).
- ACC_W, 14, signed accumulator width. Must satisfy ACC_W >= clog2(M*128)+1.
- IDX_W, 5, synapse index width. Must satisfy 2**IDX_W >= M.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- start  input  1  request one accumulation pass. Accepted only in IDLE or DONE.
- input_spikes  input  M  spike vector. Snapshot taken on the accepted start.
- weights  input  M*8  flattened signed weights; weight i is at weights[i*8 +: 8]. Must be held stable while busy.
- busy  output  1  high while in ACCUM.
- done  output  1  one-cycle pulse when input_current updates.
- input_current  output  8  signed clipped result. Holds its value between passes.
- syn_idx  output  IDX_W  synapse index being accumulated. 0 when not busy.

Behaviour:
- Reset (reset=0 at a clk edge), dominant over everything else:
  - state <= IDLE
  - acc, syn_idx, spike snapshot <= 0
  - busy, done <= 0
  - input_current <= 8'h00
- A reset in mid-pass discards the pass; no done pulse is produced.
- States:
  - IDLE: start=1 loads the snapshot from input_spikes, sets acc=0 and syn_idx=0, and moves to ACCUM.
  - ACCUM: each cycle, if snap[syn_idx]=1 then acc <= acc + sign_extend(weight[syn_idx]). syn_idx increments. When syn_idx==M-1, this final add occurs and state moves to DONE.
  - DONE, one cycle:
    - input_current <= clip(acc); done=1.
    - If start=1 in the same cycle, a new pass is accepted: new snapshot, acc=0, syn_idx=0, next state ACCUM (back-to-back, no idle cycle).
    - Otherwise next state is IDLE.
- start while in ACCUM is ignored. It is not queued.
- Latency: start sampled at edge t gives busy high for edges t+1..t+M and done high in the cycle after edge t+M+1. That is M+1 cycles from acceptance to result.
- Arithmetic:
  - acc is signed ACC_W bits.
  - For M=24 the range is -3072..+3048, so acc never overflows.
  - No intermediate saturation.
- clip(): result > 127 gives 8'h7F; result < -128 gives 8'h80; otherwise the low 8 bits.
- All-zero spikes: the pass still takes M cycles and the result is 0.
- Outputs are registered. syn_idx does not wrap beyond M-1.

Optional Feature:
- Macro: INPUT_CURRENT_CLIP_EN.
- Defined: input_current = clip(acc), as above.
- Undefined: input_current = acc[7:0] (two's-complement wrap). The clip logic is not synthesised.
- Accumulation and timing are identical in both builds.

Decomposition:
- Shared package snn_pkg holds:
  - state encoding typedef: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2
  - localparam WEIGHT_W=8
  - constant function clog2, used to check ACC_W and IDX_W
- One natural sub-module: current_clip. It is a combinational ACC_W-to-8 signed saturator, instantiated only under INPUT_CURRENT_CLIP_EN.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles mid-pass, then release. Required: input_current=0x00, busy=0, done=0, and no done pulse until a new start.
- Single spike: spikes=24'h000020 (bit 5), weight5=0x10, all others 0x55, start. Required: done exactly M+1=25 cycles after acceptance, with input_current=0x10.
- Positive overflow: all spikes set, all weights 0x7F. Required: with CLIP_EN, 0x7F; without CLIP_EN, 3048 mod 256 = 0xE8.
- Negative overflow and mixed sign:
  - all spikes set, weights 0x80: required 0x80 (clip) and 0x00 (no clip)
  - spikes {0,1} set with weights 0x05 and 0xFD: required 0x02
- Handshake:
  - start pulsed during ACCUM: ignored, exactly one done is produced.
  - start asserted in the DONE cycle: busy goes high the next cycle, and a second done follows 25 cycles after the first.
- Snapshot: change input_spikes from 0xFFFFFF to 0 one cycle after start, with all weights 0x01. Required: result 0x18, because the snapshot is used.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath blocks.
//   state_t  : sequencer state encoding (IDLE / ACCUM / DONE)
//   WEIGHT_W : width of one signed synaptic weight
//   clog2()  : elaboration-time ceil(log2) used for parameter sanity checks
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WEIGHT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/current_clip.sv
// Combinational signed saturator from an ACC_W-bit accumulator to an 8-bit
// input current. Only instantiated when INPUT_CURRENT_CLIP_EN is defined.
//   acc     : signed accumulator value (ACC_W bits)
//   current : saturated result, 0x7F above +127, 0x80 below -128
module current_clip
    import snn_pkg::*;
#(
    parameter int ACC_W = 14
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic        [WEIGHT_W-1:0] current
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-128);

    always_comb begin
        current = acc[WEIGHT_W-1:0];
        if (acc > MAX_V) begin
            current = 8'h7F;
        end else if (acc < MIN_V) begin
            current = 8'h80;
        end
    end

endmodule

// File: rtl/input_current_scheduler.sv
// Serial input-current sequencer: walks synapse 0..M-1, one per cycle,
// adding the signed weight of every synapse whose snapshotted spike bit is
// set, then publishes the 8-bit result with a one-cycle done pulse.
// Optional build macro INPUT_CURRENT_CLIP_EN: when defined the result is
// saturated to [-128,127]; otherwise it is the low 8 bits of the sum.
//   clk           : rising-edge clock
//   reset         : synchronous reset, active low
//   start         : request a pass (accepted in IDLE or DONE)
//   input_spikes  : spike vector, captured on an accepted start
//   weights       : flattened signed weights, weight i at [i*8 +: 8]
//   busy          : high while accumulating
//   done          : one-cycle pulse when input_current updates
//   input_current : signed 8-bit result, held between passes
//   syn_idx       : synapse currently accumulated, 0 when idle
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | adding weight[syn_idx] when its spike is set, one synapse per cycle
// DONE  | final sum available; publish result, optionally accept next start
module input_current_scheduler
    import snn_pkg::*;
#(
    parameter int M     = 24,
    parameter int ACC_W = 14,
    parameter int IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [M-1:0]          input_spikes,
    input  logic [M*WEIGHT_W-1:0] weights,
    output logic                  busy,
    output logic                  done,
    output logic [WEIGHT_W-1:0]   input_current,
    output logic [IDX_W-1:0]      syn_idx
);

    if (ACC_W < clog2(M * 128) + 1) begin : g_bad_acc_w
        $error("ACC_W too small for M synapses");
    end
    if ((1 << IDX_W) < M) begin : g_bad_idx_w
        $error("IDX_W too small for M synapses");
    end

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [M-1:0]               snap_q, snap_d;
    logic [IDX_W-1:0]           idx_d;
    logic                       busy_d, done_d;
    logic [WEIGHT_W-1:0]        cur_d;
    logic [WEIGHT_W-1:0]        cur_result;
    logic [WEIGHT_W-1:0]        cur_weight;
    logic signed [ACC_W-1:0]    cur_weight_ext;

    assign cur_weight     = weights[32'(syn_idx)*WEIGHT_W +: WEIGHT_W];
    assign cur_weight_ext = {{(ACC_W-WEIGHT_W){cur_weight[WEIGHT_W-1]}}, cur_weight};

`ifdef INPUT_CURRENT_CLIP_EN
    current_clip #(.ACC_W(ACC_W)) u_current_clip (
        .acc     (acc_q),
        .current (cur_result)
    );
`else
    assign cur_result = acc_q[WEIGHT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            snap_q        <= '0;
            syn_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            input_current <= 8'h00;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            snap_q        <= snap_d;
            syn_idx       <= idx_d;
            busy          <= busy_d;
            done          <= done_d;
            input_current <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        idx_d   = syn_idx;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cur_d   = input_current;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = input_spikes;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (snap_q[syn_idx]) begin
                    acc_d = acc_q + cur_weight_ext;
                end
                // Last synapse: index returns to 0 so it reads 0 when not busy.
                if (syn_idx == IDX_W'(M-1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d  = syn_idx + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                cur_d  = cur_result;
                done_d = 1'b1;
                if (start) begin
                    snap_d  = input_spikes;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_input_current_scheduler.sv
module tb_input_current_scheduler;

    localparam int M = 24;

`ifdef INPUT_CURRENT_CLIP_EN
    localparam logic [7:0] EXP_POS = 8'h7F;
    localparam logic [7:0] EXP_NEG = 8'h80;
`else
    localparam logic [7:0] EXP_POS = 8'hE8;
    localparam logic [7:0] EXP_NEG = 8'h00;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [M-1:0]     input_spikes = '0;
    logic [M*8-1:0]   weights = '0;
    logic             busy;
    logic             done;
    logic [7:0]       input_current;
    logic [4:0]       syn_idx;

    logic [M*8-1:0]   w;
    int               checks = 0;
    int               errors = 0;
    int               lat;
    int               dcount;

    always #5 clk = ~clk;

    input_current_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .input_spikes  (input_spikes),
        .weights       (weights),
        .busy          (busy),
        .done          (done),
        .input_current (input_current),
        .syn_idx       (syn_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [M*8-1:0] fill(input logic [7:0] v);
        logic [M*8-1:0] r;
        for (int i = 0; i < M; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    // Steps after an accepted start until done is seen; 0 if it never comes.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run_pass(input string tag, input logic [M-1:0] spikes,
                            input logic [M*8-1:0] wv, input logic [7:0] exp);
        int n;
        input_spikes = spikes;
        weights      = wv;
        start        = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'd25);
        chk({tag, "_cur"}, 32'(input_current), 32'(exp));
        step();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(input_current), 32'(exp));
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cur", 32'(input_current), 32'h00);
        chk("rst_idx", 32'(syn_idx), 32'd0);
        reset = 1'b1;
        step();

        w = fill(8'h55);
        w[5*8 +: 8] = 8'h10;
        run_pass("single", 24'h000020, w, 8'h10);

        run_pass("pos_ovf", 24'hFFFFFF, fill(8'h7F), EXP_POS);
        run_pass("neg_ovf", 24'hFFFFFF, fill(8'h80), EXP_NEG);
        run_pass("zero_spk", 24'h000000, fill(8'h7F), 8'h00);

        w = fill(8'h33);
        w[0 +: 8] = 8'h05;
        w[8 +: 8] = 8'hFD;
        run_pass("mixed", 24'h000003, w, 8'h02);

        // Reset in the middle of a pass
        input_spikes = 24'hFFFFFF;
        weights      = fill(8'h01);
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("mid_idx", 32'(syn_idx), 32'd4);
        reset = 1'b0;
        repeat (3) step();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_cur", 32'(input_current), 32'h00);
        chk("midrst_idx", 32'(syn_idx), 32'd0);
        reset = 1'b1;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) dcount++;
        end
        chk("midrst_nodone", 32'(dcount), 32'd0);

        // start during ACCUM is ignored
        input_spikes = 24'hFFFFFF;
        weights      = fill(8'h01);
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        dcount = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (done) dcount++;
        end
        chk("ign_dones", 32'(dcount), 32'd1);
        chk("ign_cur", 32'(input_current), 32'h18);

        // Back-to-back start in the DONE cycle
        w = fill(8'h55);
        w[5*8 +: 8] = 8'h10;
        input_spikes = 24'h000020;
        weights      = w;
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (24) step();
        chk("b2b_dstate_busy", 32'(busy), 32'd0);
        chk("b2b_dstate_done", 32'(done), 32'd0);
        w = fill(8'h33);
        w[0 +: 8] = 8'h05;
        w[8 +: 8] = 8'hFD;
        input_spikes = 24'h000003;
        weights      = w;
        start        = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_cur1", 32'(input_current), 32'h10);
        wait_done(lat);
        chk("b2b_gap", 32'(lat), 32'd25);
        chk("b2b_cur2", 32'(input_current), 32'h02);

        // Spike snapshot taken at start
        weights      = fill(8'h01);
        input_spikes = 24'hFFFFFF;
        start        = 1'b1;
        step();
        start        = 1'b0;
        input_spikes = 24'h000000;
        wait_done(lat);
        chk("snap_lat", 32'(lat), 32'd25);
        chk("snap_cur", 32'(input_current), 32'h18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
